// File: rtl/muldiv_unit.sv
// Iterative multiply / divide unit with HI/LO result registers.
// Multiply uses radix-2 shift-add, divide uses radix-2 restoring division,
// one bit per cycle. Signed operations iterate on magnitudes and the sign is
// fixed up in a final FIX cycle, together with the MADD/MSUB accumulation.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        operation request (only looked at while idle)
//   func         operation code (selector::muldiv_function)
//   op_a, op_b   rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   hi_in, lo_in accumulator source for MADD/MSUB variants
//   cancel       flush: aborts an in-flight operation, blocks a start
//   busy         high while an operation is in flight
//   done         one-cycle pulse when hi/lo carry a new result
//   hi, lo       registered results, held between operations

package selector;
  typedef enum logic [3:0] {
    MULDIV_NCARE = 4'd0,
    MULDIV_MULT  = 4'd1,
    MULDIV_MULTU = 4'd2,
    MULDIV_DIV   = 4'd3,
    MULDIV_DIVU  = 4'd4,
    MULDIV_MADD  = 4'd5,
    MULDIV_MADDU = 4'd6,
    MULDIV_MSUB  = 4'd7,
    MULDIV_MSUBU = 4'd8
  } muldiv_function;
endpackage

module muldiv_unit
  import selector::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  muldiv_function       func,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic [WIDTH-1:0]     hi_in,
  input  logic [WIDTH-1:0]     lo_in,
  input  logic                 cancel,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned DW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, next_state;

  // Operation context captured at acceptance
  muldiv_function   func_q;
  logic [WIDTH-1:0] divisor_q;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] dividend_q;  // raw op_a, returned as hi on divide by zero
  logic [DW-1:0]    acc_q;       // {hi_in, lo_in}
  logic             neg_q;       // product / quotient must be negated
  logic             rem_neg_q;   // remainder must be negated
  logic             divz_q;      // divisor was zero
  logic [CNT_W-1:0] cnt;

  // Working pair: product {hi,lo} for multiply, {remainder,quotient} for divide
  logic [WIDTH-1:0] work_hi, work_lo;

  logic             accept;
  logic             in_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             is_div_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [DW-1:0]    prod_raw, prod_signed, result;
  logic [WIDTH-1:0] quot, rem;

  // Operand decode and magnitude extraction
  always_comb begin
    in_signed = (func == MULDIV_MULT) || (func == MULDIV_DIV) ||
                (func == MULDIV_MADD) || (func == MULDIV_MSUB);
    accept    = (state == IDLE) && start && !cancel && (func != MULDIV_NCARE);
    a_neg     = in_signed && op_a[WIDTH-1];
    b_neg     = in_signed && op_b[WIDTH-1];
    a_mag     = a_neg ? WIDTH'(-op_a) : op_a;
    b_mag     = b_neg ? WIDTH'(-op_b) : op_b;
  end

  // One iteration step for each algorithm
  always_comb begin
    is_div_q  = (func_q == MULDIV_DIV) || (func_q == MULDIV_DIVU);
    mul_sum   = {1'b0, work_hi} + ({1'b0, divisor_q} & {(WIDTH+1){work_lo[0]}});
    div_shift = {work_hi, work_lo[WIDTH-1]};
    // MSB set means the trial subtraction borrowed: restore
    div_diff  = div_shift - {1'b0, divisor_q};
  end

  // Sign correction and accumulation, evaluated in FIX
  always_comb begin
    prod_raw    = {work_hi, work_lo};
    prod_signed = neg_q ? DW'(-prod_raw) : prod_raw;
    quot        = divz_q ? {WIDTH{1'b1}} : (neg_q ? WIDTH'(-work_lo) : work_lo);
    rem         = divz_q ? dividend_q : (rem_neg_q ? WIDTH'(-work_hi) : work_hi);
    case (func_q)
      MULDIV_MADD, MULDIV_MADDU: result = acc_q + prod_signed;
      MULDIV_MSUB, MULDIV_MSUBU: result = acc_q - prod_signed;
      MULDIV_DIV,  MULDIV_DIVU:  result = {rem, quot};
      default:                   result = prod_signed;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = CALC;
      CALC: begin
        if (cancel)                           next_state = IDLE;
        else if (cnt == CNT_W'(WIDTH - 1))    next_state = FIX;
      end
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else begin
      busy <= (next_state != IDLE);
      done <= (state == FIX) && !cancel;
      if ((state == FIX) && !cancel) begin
        hi <= result[DW-1:WIDTH];
        lo <= result[WIDTH-1:0];
      end
    end
  end

  // Datapath: latch context on accept, iterate in CALC
  always_ff @(posedge clk) begin
    if (accept) begin
      func_q     <= func;
      divisor_q  <= b_mag;
      dividend_q <= op_a;
      acc_q      <= {hi_in, lo_in};
      neg_q      <= a_neg ^ b_neg;
      rem_neg_q  <= a_neg;
      divz_q     <= (op_b == '0);
      work_hi    <= '0;
      work_lo    <= a_mag;
      cnt        <= '0;
    end else if (state == CALC) begin
      cnt <= cnt + CNT_W'(1);
      if (is_div_q) begin
        work_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        work_lo <= {work_lo[WIDTH-2:0], ~div_diff[WIDTH]};
      end else begin
        work_hi <= mul_sum[WIDTH:1];
        work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a WIDTH=32 instance checked every cycle
// against a timing/arithmetic model plus literal expectations, and a WIDTH=8
// instance exercised with random operations of every function.
module tb_muldiv_unit;
  import selector::*;

  logic clk, reset;

  logic           start, cancel, busy, done;
  muldiv_function func;
  logic [31:0]    op_a, op_b, hi_in, lo_in, hi, lo;

  logic           n8_start, n8_cancel, n8_busy, n8_done;
  muldiv_function n8_func;
  logic [7:0]     n8_a, n8_b, n8_hi_in, n8_lo_in, n8_hi, n8_lo;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start), .func(func),
    .op_a(op_a), .op_b(op_b), .hi_in(hi_in), .lo_in(lo_in),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(n8_start), .func(n8_func),
    .op_a(n8_a), .op_b(n8_b), .hi_in(n8_hi_in), .lo_in(n8_lo_in),
    .cancel(n8_cancel), .busy(n8_busy), .done(n8_done), .hi(n8_hi), .lo(n8_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arithmetic reference: returns {hi,lo} in the low 2*w bits
  function automatic logic [63:0] ref_calc(input int w, input muldiv_function f,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] hin, input logic [31:0] lin);
    logic [63:0] mask, mask2, ua, ub, acc, sprod, uprod, res;
    longint sa, sb, q, r;
    mask  = (64'd1 << w) - 64'd1;
    mask2 = (w == 32) ? {64{1'b1}} : ((64'd1 << (2 * w)) - 64'd1);
    ua    = 64'(a) & mask;
    ub    = 64'(b) & mask;
    sa    = a[w-1] ? longint'(ua) - longint'(mask) - 64'sd1 : longint'(ua);
    sb    = b[w-1] ? longint'(ub) - longint'(mask) - 64'sd1 : longint'(ub);
    acc   = ((64'(hin) & mask) << w) | (64'(lin) & mask);
    sprod = 64'(sa * sb);
    uprod = ua * ub;
    case (f)
      MULDIV_MULT:  res = sprod;
      MULDIV_MULTU: res = uprod;
      MULDIV_MADD:  res = acc + sprod;
      MULDIV_MADDU: res = acc + uprod;
      MULDIV_MSUB:  res = acc - sprod;
      MULDIV_MSUBU: res = acc - uprod;
      MULDIV_DIV: begin
        if (ub == 64'd0) begin
          q = longint'(mask);
          r = longint'(ua);
        end else begin
          q = sa / sb;
          r = sa % sb;
        end
        res = ((64'(r) & mask) << w) | (64'(q) & mask);
      end
      MULDIV_DIVU: begin
        if (ub == 64'd0) res = (ua << w) | mask;
        else             res = ((ua % ub) << w) | (ua / ub);
      end
      default: res = 64'd0;
    endcase
    return res & mask2;
  endfunction

  // Cycle-level model of the 32-bit instance: an accepted op is busy for 33 cycles
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  bit          m_busy, m_done, m_valid;
  int          m_left;

  initial begin
    m_valid = 1'b0;
    m_left  = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
      m_valid = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (cancel) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_done = 1'b1;
            {m_hi, m_lo} = m_pend;
          end
        end
      end else if (start && !cancel && func != MULDIV_NCARE) begin
        m_pend = ref_calc(32, func, op_a, op_b, hi_in, lo_in);
        m_left = 33;
      end
      m_busy = (m_left > 0);
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_busy", 64'(busy), 64'(m_busy));
      check("cmp_done", 64'(done), 64'(m_done));
      check("cmp_hi",   64'(hi),   64'(m_hi));
      check("cmp_lo",   64'(lo),   64'(m_lo));
    end
  end

  // Issue at the current negedge, return at the negedge of the done cycle
  task automatic run_op(input string name, input muldiv_function f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hin, input logic [31:0] lin,
                        input logic [31:0] eh, input logic [31:0] el);
    bit seen;
    check({"model_", name}, ref_calc(32, f, a, b, hin, lin), {eh, el});
    func = f; op_a = a; op_b = b; hi_in = hin; lo_in = lin; start = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Scramble inputs: the operation must use the latched values
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; hi_in = $urandom; lo_in = $urandom;
        func = MULDIV_MULTU;
      end
      if (done) begin
        seen = 1'b1;
        check({name, "_cycle"}, 64'(k), 64'd34);
        check({name, "_hi"}, 64'(hi), 64'(eh));
        check({name, "_lo"}, 64'(lo), 64'(el));
      end
    end
    if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  function automatic muldiv_function pick_func(input int idx);
    case (idx)
      0: return MULDIV_MULT;
      1: return MULDIV_MULTU;
      2: return MULDIV_DIV;
      3: return MULDIV_DIVU;
      4: return MULDIV_MADD;
      5: return MULDIV_MADDU;
      6: return MULDIV_MSUB;
      default: return MULDIV_MSUBU;
    endcase
  endfunction

  initial begin
    bit seen;
    int ndone;
    logic [63:0] exp8;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; func = MULDIV_NCARE;
    op_a = '0; op_b = '0; hi_in = '0; lo_in = '0;
    n8_start = 1'b0; n8_cancel = 1'b0; n8_func = MULDIV_NCARE;
    n8_a = '0; n8_b = '0; n8_hi_in = '0; n8_lo_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_lo",   64'(lo),   64'd0);
    check("rst8_hilo", 64'({n8_busy, n8_done, n8_hi, n8_lo}), 64'd0);
    check("pin8_div", ref_calc(8, MULDIV_DIV, 32'hF9, 32'h02, 0, 0), 64'hFFFD);

    // First start in the first cycle after reset; the rest chain back-to-back
    reset = 1'b0;
    run_op("mult",   MULDIV_MULT,  32'hFFFFFFFD, 32'd7,        0, 0,            32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_neg",MULDIV_DIV,   32'hFFFFFFF9, 32'd2,        0, 0,            32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_z", MULDIV_DIVU,  32'd5,        32'd0,        0, 0,            32'd5,        32'hFFFFFFFF);
    run_op("div_ovf",MULDIV_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0,            32'd0,        32'h80000000);
    run_op("msubu",  MULDIV_MSUBU, 32'd1,        32'd1,        0, 0,            32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("madd_c", MULDIV_MADD,  32'd1,        32'd1,        0, 32'hFFFFFFFF, 32'd1,        32'd0);
    run_op("multu",  MULDIV_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0,            32'hFFFFFFFE, 32'h00000001);
    run_op("div_nb", MULDIV_DIV,   32'd7,        32'hFFFFFFFE, 0, 0,            32'd1,        32'hFFFFFFFD);
    run_op("maddu",  MULDIV_MADDU, 32'h10000,    32'h10000,    1, 2,            32'd2,        32'd2);
    run_op("msub",   MULDIV_MSUB,  32'hFFFFFFFF, 32'd1,        0, 0,            32'd0,        32'd1);

    // Cancel in cycle 10 of a MULTU: idle next cycle, no done, hi/lo kept
    @(negedge clk);
    func = MULDIV_MULTU; op_a = 32'd3; op_b = 32'd5; start = 1'b1; ndone = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 10) cancel = 1'b1;
      if (k == 11) begin
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
      end
      if (done) ndone++;
    end
    check("cancel_nodone", 64'(ndone), 64'd0);
    check("cancel_hilo", {hi, lo}, {32'd0, 32'd1});

    // Start held high through busy is not queued
    func = MULDIV_MULT; op_a = 32'd6; op_b = 32'hFFFFFFFE; start = 1'b1; ndone = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 20) start = 1'b0;
      if (done) begin
        if (ndone == 0) begin
          check("held_cycle", 64'(k), 64'd34);
          check("held_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFF4});
        end
        ndone++;
      end
    end
    check("held_ndone", 64'(ndone), 64'd1);

    // Reset in cycle 5 discards the operation
    func = MULDIV_MULTU; op_a = 32'd9; op_b = 32'd9; start = 1'b1; ndone = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 5) reset = 1'b1;
      if (k == 6) begin
        reset = 1'b0;
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
      end
      if (done) ndone++;
    end
    check("rst_mid_nodone", 64'(ndone), 64'd0);

    // NCARE and cancel-with-start are both ignored in IDLE
    func = MULDIV_NCARE; start = 1'b1;
    @(negedge clk);
    check("ncare_busy", 64'(busy), 64'd0);
    func = MULDIV_MULT; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_idle_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);

    // WIDTH=8 random operations of every function
    for (int i = 0; i < 48; i++) begin
      n8_func  = pick_func(i % 8);
      n8_a     = 8'($urandom_range(0, 255));
      n8_b     = (i % 7 == 3) ? 8'd0 : 8'($urandom_range(0, 255));
      if (i == 10) begin n8_a = 8'h80; n8_b = 8'hFF; end
      n8_hi_in = 8'($urandom_range(0, 255));
      n8_lo_in = 8'($urandom_range(0, 255));
      exp8 = ref_calc(8, n8_func, 32'(n8_a), 32'(n8_b), 32'(n8_hi_in), 32'(n8_lo_in));
      n8_start = 1'b1;
      seen = 1'b0;
      for (int k = 1; k <= 30 && !seen; k++) begin
        @(negedge clk);
        if (k == 1) begin
          n8_start = 1'b0;
          n8_a = 8'($urandom); n8_b = 8'($urandom);
          n8_hi_in = 8'($urandom); n8_lo_in = 8'($urandom);
        end
        if (n8_done) begin
          seen = 1'b1;
          check($sformatf("r8_%0d_cycle", i), 64'(k), 64'd10);
          check($sformatf("r8_%0d_hilo", i), 64'({n8_hi, n8_lo}), exp8);
        end
      end
      if (!seen) check($sformatf("r8_%0d_timeout", i), 64'd0, 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL have the parameter WIDTH, default 32, giving the operand and HI/LO width; legal values are even and at least 4.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 func  input  selector::muldiv_function  operation code: MULDIV_MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU or NCARE.
REQ-006 op_a  input  WIDTH  rs operand: multiplicand or dividend.
REQ-007 op_b  input  WIDTH  rt operand: multiplier or divisor.
REQ-008 hi_in, lo_in  input  WIDTH each  accumulator source for MADD/MSUB variants.
REQ-009 cancel  input  1  pipeline flush; aborts any in-flight operation.
REQ-010 busy  output  1  high while an operation is in flight.
REQ-011 done  output  1  one-cycle pulse marking new hi/lo.
REQ-012 hi, lo  output  WIDTH each  registered results; held between operations.

Function
REQ-013 The FSM SHALL have the states IDLE, CALC and FIX: IDLE->CALC on an accepted start, CALC->FIX after exactly WIDTH iterations, and FIX->IDLE always.
REQ-014 A start SHALL be accepted when state=IDLE, start=1, cancel=0 and func!=MULDIV_NCARE; otherwise the block stays in IDLE with no side effects.
REQ-015 On acceptance the block SHALL latch op_a, op_b, hi_in, lo_in and func; later changes to these inputs have no effect on the operation.
REQ-016 Signed ops SHALL iterate on magnitudes and apply sign correction in FIX; unsigned ops SHALL iterate on raw values.
REQ-017 Multiply SHALL use radix-2 shift-add and divide SHALL use radix-2 restoring division, one bit per CALC cycle.
REQ-018 Timing: with start accepted in cycle 0, busy=1 in cycles 1..WIDTH+1, and hi/lo update and done=1 in cycle WIDTH+2 only.
REQ-019 In the done cycle busy=0 and state=IDLE, so a new start SHALL be accepted in that same cycle (back-to-back).
REQ-020 MULT/MULTU SHALL produce {hi,lo} = full 2*WIDTH-bit product.
REQ-021 MADD/MADDU SHALL produce {hi,lo} = {hi_in,lo_in} + product, modulo 2^(2*WIDTH).
REQ-022 MSUB/MSUBU SHALL produce {hi,lo} = {hi_in,lo_in} - product, modulo 2^(2*WIDTH).
REQ-023 DIV/DIVU SHALL produce lo = quotient and hi = remainder; signed division truncates toward zero and the remainder takes the sign of the dividend.
REQ-024 Divide by zero SHALL complete at normal latency with lo = all ones and hi = op_a.
REQ-025 Signed overflow (DIV of the most negative value by -1) SHALL produce lo = most negative value and hi = 0.
REQ-026 start while busy=1 SHALL be ignored; it is not queued.
REQ-027 cancel=1 in CALC or FIX SHALL return the block to IDLE next cycle with busy=0, no done pulse and hi/lo unchanged.
REQ-028 cancel=1 in IDLE SHALL suppress a simultaneous start.
REQ-029 cancel in the done cycle SHALL NOT retract the done pulse or the hi/lo update.

Reset
REQ-030 reset=1 at a clock edge SHALL force state=IDLE, busy=0, done=0, hi=0 and lo=0, regardless of state; it overrides start and cancel.
REQ-031 Reset mid-operation SHALL discard the operation with no done pulse.
REQ-032 The first start SHALL be accepted in the first cycle after reset deasserts.

Verification
REQ-033 WIDTH=32, MULT a=0xFFFFFFFD, b=7, start in cycle 0 -> done only in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy=1 in cycles 1..33.
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
REQ-035 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; MSUBU hi_in=0, lo_in=0, a=1, b=1 -> hi=lo=0xFFFFFFFF.
REQ-036 MADD hi_in=0, lo_in=0xFFFFFFFF, a=1, b=1 -> hi=1, lo=0 (carry into hi); a second start issued in the done cycle completes 34 cycles later.
REQ-037 cancel asserted in cycle 10 of a MULTU -> busy=0 in cycle 11, no done, hi/lo keep prior values; start held during busy is ignored; reset in cycle 5 -> hi=lo=0, no done.
REQ-038 WIDTH=8, randomized ops of every func against a reference model -> exact hi/lo match, with done always in cycle 10.
